// File: rtl/systolic_2x2_driver.sv
// Host-side stream driver for the registered 2x2 systolic array: gathers A/B operands,
// presents them packed on mi0/mi1, captures the array result and streams C back out.
module systolic_2x2_driver #(
  parameter int unsigned SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_data,
  output logic [4*SIZE-1:0] arr_mi0,
  output logic [4*SIZE-1:0] arr_mi1,
  input  logic [4*SIZE-1:0] arr_mor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE-1:0]   out_data,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       mat_count
);

  typedef enum logic [1:0] {StLoad, StIssue, StWait, StDrain} state_e;

  state_e              state_q;
  logic [2:0]          ld_cnt_q;
  logic [1:0]          dr_cnt_q;
  logic [4*SIZE-1:0]   res_q;
  logic [1:0]          ld_slot;
  logic [1:0]          dr_slot;
  logic                in_fire;
  logic                out_fire;

  // Element 0 sits in the MSB slice, so slice index from the LSB is 3-k.
  assign ld_slot  = ~ld_cnt_q[1:0];
  assign dr_slot  = ~dr_cnt_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    in_ready  = rst && (state_q == StLoad);
    out_valid = (state_q == StDrain);
    busy      = (state_q != StLoad);
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = res_q[dr_slot*SIZE +: SIZE];
      out_last = (dr_cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StLoad;
      ld_cnt_q  <= '0;
      dr_cnt_q  <= '0;
      arr_mi0   <= '0;
      arr_mi1   <= '0;
      res_q     <= '0;
      mat_count <= '0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (in_fire) begin
            if (ld_cnt_q[2]) arr_mi1[ld_slot*SIZE +: SIZE] <= in_data;
            else             arr_mi0[ld_slot*SIZE +: SIZE] <= in_data;
            ld_cnt_q <= ld_cnt_q + 3'd1;
            if (ld_cnt_q == 3'd7) state_q <= StIssue;
          end
        end
        // The array registers its product at the edge closing this state.
        StIssue: state_q <= StWait;
        StWait: begin
          res_q    <= arr_mor;
          dr_cnt_q <= '0;
          state_q  <= StDrain;
        end
        StDrain: begin
          if (out_fire) begin
            dr_cnt_q <= dr_cnt_q + 2'd1;
            if (dr_cnt_q == 2'd3) begin
              mat_count <= mat_count + 16'd1;
              state_q   <= StLoad;
            end
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

endmodule
